// File: rtl/rle_pixel_encoder_if.sv
// Handshake bundle between an RGB332 pixel source, the RLE encoder and the word consumer.
// master = pixel source / word sink side, slave = encoder side.
interface rle_pixel_encoder_if;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_eol;
  logic        pix_eof;
  logic        pix_ready;
  logic [17:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output pix_data, pix_valid, pix_eol, pix_eof, out_ready,
    input  pix_ready, out_data, out_valid
  );

  modport slave (
    input  pix_data, pix_valid, pix_eol, pix_eof, out_ready,
    output pix_ready, out_data, out_valid
  );
endinterface

// File: rtl/rle_pixel_encoder.sv
// Streaming RLE encoder: RGB332 pixels in, 18-bit RUN/STOP instruction words out.
// Optional RLE_STATS_EN adds word/pixel transfer counters.
//
// state    | meaning
// ST_IDLE  | no run open, waiting for the first pixel of a run
// ST_RUN   | run {cur_col, cur_len} open, extending or closing it
// ST_CLOSE | a run was emitted on eol; the new one-pixel run still has to go out
// ST_STOP  | frame ended, STOP word pending
module rle_pixel_encoder #(
  parameter int MAX_RUN = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  rle_pixel_encoder_if.slave bus
`ifdef RLE_STATS_EN
  ,
  output logic [15:0]        stat_words,
  output logic [23:0]        stat_pixels
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CLOSE, ST_STOP} state_t;

  localparam logic [1:0]  OP_RUN    = 2'b00;
  localparam logic [17:0] STOP_WORD = 18'h30000;
  localparam logic [7:0]  LEN_MAX   = 8'(MAX_RUN - 1);

  state_t      state, state_nxt;
  logic [7:0]  cur_col, col_nxt;
  logic [7:0]  cur_len, len_nxt;
  logic        eof_pend, eof_nxt;
  logic        emit;
  logic [17:0] emit_word;
  logic        ostall, accept_ok, take, last;

  assign ostall = bus.out_valid & ~bus.out_ready;
  assign take   = bus.pix_valid & accept_ok;
  assign last   = bus.pix_eol | bus.pix_eof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cur_col  <= 8'h00;
      cur_len  <= 8'h00;
      eof_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_col  <= col_nxt;
      cur_len  <= len_nxt;
      eof_pend <= eof_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = cur_col;
    len_nxt   = cur_len;
    eof_nxt   = eof_pend;
    emit      = 1'b0;
    emit_word = {OP_RUN, cur_col, cur_len};
    if (take && bus.pix_eof) eof_nxt = 1'b1;
    case (state)
      ST_IDLE: begin
        if (take) begin
          if (last) begin
            emit      = 1'b1;
            emit_word = {OP_RUN, bus.pix_data, 8'h00};
            state_nxt = bus.pix_eof ? ST_STOP : ST_IDLE;
          end else begin
            col_nxt   = bus.pix_data;
            len_nxt   = 8'h00;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (take) begin
          if (bus.pix_data == cur_col && cur_len < LEN_MAX) begin
            len_nxt = cur_len + 8'd1;
            if (last) begin
              emit      = 1'b1;
              emit_word = {OP_RUN, cur_col, cur_len + 8'd1};
              state_nxt = bus.pix_eof ? ST_STOP : ST_IDLE;
            end
          end else begin
            // Colour change or full run: flush the old run, the new pixel starts another.
            emit      = 1'b1;
            emit_word = {OP_RUN, cur_col, cur_len};
            col_nxt   = bus.pix_data;
            len_nxt   = 8'h00;
            if (last) state_nxt = ST_CLOSE;
          end
        end
      end
      ST_CLOSE: begin
        if (!ostall) begin
          emit      = 1'b1;
          emit_word = {OP_RUN, cur_col, cur_len};
          state_nxt = eof_pend ? ST_STOP : ST_IDLE;
        end
      end
      ST_STOP: begin
        if (!ostall) begin
          emit      = 1'b1;
          emit_word = STOP_WORD;
          eof_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept_ok     = rst_n & (state == ST_IDLE || state == ST_RUN) & ~ostall;
    bus.pix_ready = accept_ok;
  end

  // Emit only ever fires when the output register is free, so nothing is overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= 18'h0;
      bus.out_valid <= 1'b0;
    end else if (emit) begin
      bus.out_data  <= emit_word;
      bus.out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef RLE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words  <= 16'h0;
      stat_pixels <= 24'h0;
    end else begin
      if (bus.out_valid && bus.out_ready) stat_words <= stat_words + 16'd1;
      if (take) stat_pixels <= stat_pixels + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_pixel_encoder.sv
// Bench for rle_pixel_encoder: directed cases plus random frames against a run-splitting model.
// Word checking is done by a scoreboard fed from the model before each frame is driven.
module tb_rle_pixel_encoder;
  localparam int MAX_RUN = 256;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rle_pixel_encoder_if bus ();
`ifdef RLE_STATS_EN
  logic [15:0] stat_words;
  logic [23:0] stat_pixels;
`endif

  rle_pixel_encoder #(.MAX_RUN(MAX_RUN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave)
`ifdef RLE_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_pixels (stat_pixels)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  pix_t        frame_q[$];
  logic [17:0] exp_q[$];
  int          rdy_pct = 100;
  bit          gap_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_data = 18'h0;
  logic [17:0] w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: split the pixel list into runs by colour, line end and MAX_RUN.
  function automatic void build_expected();
    int         cnt = 0;
    logic [7:0] col = 8'h00;
    foreach (frame_q[i]) begin
      if (cnt > 0 && (frame_q[i].d != col || cnt == MAX_RUN)) begin
        exp_q.push_back({2'b00, col, 8'(cnt - 1)});
        cnt = 0;
      end
      col = frame_q[i].d;
      cnt++;
      if (frame_q[i].eol || frame_q[i].eof) begin
        exp_q.push_back({2'b00, col, 8'(cnt - 1)});
        cnt = 0;
      end
      if (frame_q[i].eof) exp_q.push_back(18'h30000);
    end
  endfunction

  task automatic add_pix(input logic [7:0] d, input int n, input bit eol, input bit eof);
    for (int i = 0; i < n; i++) begin
      pix_t p;
      p.d   = d;
      p.eol = (i == n - 1) ? (eol | eof) : 1'b0;
      p.eof = (i == n - 1) ? eof : 1'b0;
      frame_q.push_back(p);
    end
  endtask

  // Called and returns at posedge+1.
  task automatic drive_frame();
    build_expected();
    foreach (frame_q[i]) begin
      int  n = 0;
      bit  acc = 1'b0;
      if (gap_en && $urandom_range(3) == 0) begin
        bus.pix_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = frame_q[i].d;
      bus.pix_eol   = frame_q[i].eol;
      bus.pix_eof   = frame_q[i].eof;
      while (!acc && n < 2000) begin
        @(negedge clk);
        acc = bus.pix_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!acc) begin
        chk("pix_accept_timeout", 32'(n), 32'(0));
        break;
      end
    end
    bus.pix_valid = 1'b0;
    bus.pix_eol   = 1'b0;
    bus.pix_eof   = 1'b0;
    frame_q.delete();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_pix_ready", 32'(bus.pix_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_pix_ready", 32'(bus.pix_ready), 32'(1));
  endtask

  always @(posedge clk) begin
    #1;
    bus.out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'(1));
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", 32'(exp_q.size()), 32'(1));
        else begin
          w = exp_q.pop_front();
          chk("word", 32'(bus.out_data), 32'(w));
        end
      end
      prev_stall <= bus.out_valid & ~bus.out_ready;
      prev_data  <= bus.out_data;
    end
  end

  initial begin
    int cnt;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'h00;
    bus.pix_eol   = 1'b0;
    bus.pix_eof   = 1'b0;
    bus.out_ready = 1'b1;
    do_reset();

    add_pix(8'hE0, 5, 1'b1, 1'b0);
    drive_frame();
    wait_drain();
    @(negedge clk);
    chk("e0_idle_ready", 32'(bus.pix_ready), 32'(1));
    @(posedge clk);
    #1;

    add_pix(8'h1C, 300, 1'b1, 1'b0);
    drive_frame();
    wait_drain();

    rdy_pct = 0;
    add_pix(8'h0A, 2, 1'b0, 1'b0);
    add_pix(8'h0B, 2, 1'b0, 1'b0);
    add_pix(8'h0C, 1, 1'b1, 1'b0);
    fork
      drive_frame();
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("stall_pix_ready", 32'(bus.pix_ready), 32'(0));
        chk("stall_pending", 32'(exp_q.size()), 32'(3));
        rdy_pct = 100;
      end
    join
    wait_drain();

    add_pix(8'h03, 3, 1'b0, 1'b0);
    add_pix(8'h07, 1, 1'b1, 1'b0);
    drive_frame();
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (!bus.pix_ready) cnt++;
      @(posedge clk);
      #1;
    end
    chk("close_low_cycles", 32'(cnt), 32'(1));
    wait_drain();

    add_pix(8'h55, 4, 1'b0, 1'b0);
    drive_frame();
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", 32'(bus.out_valid), 32'(0));
    chk("midrun_rst_data", 32'(bus.out_data), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    add_pix(8'h55, 1, 1'b1, 1'b0);
    drive_frame();
    wait_drain();

    do_reset();
    add_pix(8'hFF, 2, 1'b1, 1'b1);
    drive_frame();
    wait_drain();
    @(negedge clk);
    chk("eof_idle_ready", 32'(bus.pix_ready), 32'(1));
`ifdef RLE_STATS_EN
    chk("stat_words", 32'(stat_words), 32'(2));
    chk("stat_pixels", 32'(stat_pixels), 32'(2));
`endif
    @(posedge clk);
    #1;

    for (int f = 0; f < 24; f++) begin
      int         len = $urandom_range(120, 10);
      int         rep = (f % 3 == 0) ? 97 : 75;
      logic [7:0] col = 8'h00;
      case ($urandom_range(2))
        0: rdy_pct = 30;
        1: rdy_pct = 70;
        default: rdy_pct = 100;
      endcase
      gap_en = ($urandom_range(1) == 1);
      for (int i = 0; i < len; i++) begin
        bit eol;
        if (i == 0 || $urandom_range(99) >= rep) col = 8'($urandom_range(3)) * 8'h25;
        eol = ($urandom_range(29) == 0);
        add_pix(col, 1, eol, (i == len - 1));
      end
      drive_frame();
      wait_drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
